// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Opcode encodings, FSM states and default datapath width.
package alu_arbiter_pkg;

   localparam int ALU_WIDTH = 4;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND = 2'b00;
   localparam op_t OP_OR  = 2'b01;
   localparam op_t OP_XOR = 2'b10;
   localparam op_t OP_ADD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer
// and the arbiter; master drives requests, slave is the arbiter.
interface alu_arbiter_if
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);

   logic             req0_valid;
   logic             req0_ready;
   op_t              req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   op_t              req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_carry;
   logic             rsp_zero;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result,
      input  rsp_carry, rsp_zero
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result,
      output rsp_carry, rsp_zero
   );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Combinational 4-op ALU: per-bit gate cells for the logic ops
// and a ripple-carry chain of full adders for ADD.
module and_bit (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module or_bit (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module xor_bit (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module alu_core
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH-1:0] and_v;
   logic [WIDTH-1:0] or_v;
   logic [WIDTH-1:0] xor_v;
   logic [WIDTH-1:0] sum_v;
   logic [WIDTH:0]   c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      and_bit u_and (.a(a[i]), .b(b[i]), .y(and_v[i]));
      or_bit  u_or  (.a(a[i]), .b(b[i]), .y(or_v[i]));
      xor_bit u_xor (.a(a[i]), .b(b[i]), .y(xor_v[i]));
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum_v[i]),
         .co (c[i+1])
      );
   end

   always_comb begin
      result = '0;
      carry  = 1'b0;
      unique case (op)
         OP_AND: result = and_v;
         OP_OR:  result = or_v;
         OP_XOR: result = xor_v;
         OP_ADD: begin
            result = sum_v;
            carry  = c[WIDTH];
         end
         default: result = '0;
      endcase
   end

   assign zero = ~|result;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Optional grant counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [7:0] gnt_cnt0,
   output logic [7:0] gnt_cnt1
`endif
);

   state_t           state;
   logic             last;
   op_t              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             id_q;

   logic             gnt0;
   logic             gnt1;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_zero;

   // On contention the requester not served last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE) begin
         gnt0 = bus.req0_valid & (~bus.req1_valid | last);
         gnt1 = bus.req1_valid & (~bus.req0_valid | ~last);
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         last           <= 1'b1;
         op_q           <= OP_AND;
         a_q            <= '0;
         b_q            <= '0;
         id_q           <= 1'b0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= 1'b0;
         bus.rsp_result <= '0;
         bus.rsp_carry  <= 1'b0;
         bus.rsp_zero   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt0 | gnt1) begin
                  op_q  <= gnt1 ? bus.req1_op : bus.req0_op;
                  a_q   <= gnt1 ? bus.req1_a : bus.req0_a;
                  b_q   <= gnt1 ? bus.req1_b : bus.req0_b;
                  id_q  <= gnt1;
                  last  <= gnt1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               bus.rsp_result <= alu_result;
               bus.rsp_carry  <= alu_carry;
               bus.rsp_zero   <= alu_zero;
               bus.rsp_id     <= id_q;
               bus.rsp_valid  <= 1'b1;
               state          <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else begin
         if (gnt0 && gnt_cnt0 != 8'hff)
            gnt_cnt0 <= gnt_cnt0 + 8'd1;
         if (gnt1 && gnt_cnt1 != 8'hff)
            gnt_cnt1 <= gnt_cnt1 + 8'd1;
      end
   end
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 4-bit ALU datapath (AND/OR/XOR/ADD) between two requesters. Grants round-robin over a valid/ready handshake, captures operands, executes one operation and holds a registered result with flags until the consumer accepts it. It sits above the per-operation gate-level modules and is the only block that drives their operands.

## Interface
- WIDTH, 4, operand and result width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  2  00 AND, 01 OR, 10 XOR, 11 ADD
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that issued the result
- rsp_result  output  WIDTH  operation result
- rsp_carry  output  1  ADD carry-out; 0 for logic ops
- rsp_zero  output  1  rsp_result == 0
- One clock domain. Reset is asynchronous and active-high.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one requester. reqN_ready is high combinationally for the granted requester only. Latch op, a, b and id, then go to EXEC.
- Arbitration: a single valid requester always wins. If both are valid, grant the one not granted last. The last-grant pointer updates on every grant.
- EXEC: compute the result from the latched operands. Register rsp_result, rsp_carry, rsp_zero and rsp_id. Go to RESP.
- RESP: rsp_valid is high. Outputs stay stable until rsp_ready is sampled high, then go to IDLE.
- Both ready outputs are 0 in EXEC and RESP. Requests are never accepted while a result is pending.
- ADD computes a WIDTH+1-bit sum. The low WIDTH bits go to rsp_result; the MSB goes to rsp_carry. The sum wraps modulo 2^WIDTH (e.g. 1111+0001 = 0000, carry 1, zero 1).
- Logic ops are bitwise. rsp_carry is 0.
- reqN_valid deasserting in IDLE before acceptance is legal; nothing is captured.

## Timing
- Reset values: state IDLE, req0_ready 0, req1_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_carry 0, rsp_zero 0.
- After reset the last-grant pointer is 1, so requester 0 wins the first contention.
- Accept in cycle N gives EXEC in N+1 and rsp_valid from N+2.
- If rsp_ready is high in N+2, IDLE is reached in N+3, and the next accept can happen in N+3. Peak throughput is one op per 3 cycles.
- rsp_ready high outside RESP is ignored.
- Reset asserted mid-operation aborts it immediately and asynchronously. The pending operation is discarded and not replayed.
- All outputs except reqN_ready are registered. reqN_ready is a function of state, both valids and the pointer.

## Configuration
- ALU_ARB_STATS_EN defined: adds outputs gnt_cnt0 and gnt_cnt1, each 8 bits.
  - Each counts grants to its requester and saturates at 255.
  - Both are cleared by rst.
  - They increment in the grant cycle.
- ALU_ARB_STATS_EN undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11
  - the FSM state encoding
  - the default WIDTH
- One sub-module: alu_core, combinational.
  - Inputs: op, a, b. Outputs: result, carry, zero.
  - Bitwise ops are built per bit from the existing gate-level operation modules. ADD is built as a ripple adder.
  - alu_arbiter instantiates it once on the latched operands.

## Test plan
- Reset, then req0 OR a=1010 b=0101 with rsp_ready held high: req0_ready pulses at cycle 0; rsp_valid at cycle 2 with result 1111, carry 0, zero 0, id 0; back to IDLE at cycle 3.
- req0 and req1 both valid continuously, each op XOR a=b=0011: grants alternate 0,1,0,1; every response has result 0000, zero 1.
- req1 ADD 1111+0001, rsp_ready low for 5 cycles then high: rsp_valid is held with result 0000, carry 1, zero 1, outputs stable all 5 cycles; no ready pulses; one response total.
- req0 AND 1100&1010 then ADD 0111+0001: results 1000/carry 0 and 1000/carry 0, zero 0 both.
- Assert rst during EXEC of a req0 op: all outputs return to reset values asynchronously; with both valid afterward, requester 0 is granted first.
- With ALU_ARB_STATS_EN: 300 grants to req0 give gnt_cnt0 = 255 (saturated) and gnt_cnt1 = 0.
